burger_column_ctrl: RTL and testbench

- Sequences all ingredient layers in one burger column of the play field, on the frame tick.
- Tracks which segments of each layer the chef has stepped on.
- Owns a single shared fall engine: only one layer moves at a time. Pending drops are granted round-robin; an impact hands the engine to the struck layer.
- Counts layers landed on the plate and flags column completion to the game FSM and sprite renderer.

---
 rtl/burger_column_ctrl_pkg.sv | 17 +
 rtl/burger_column_ctrl_if.sv | 33 +++
 rtl/burger_column_ctrl_rr_arbiter.sv | 33 +++
 rtl/burger_column_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_burger_column_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/burger_column_ctrl_pkg.sv
// Shared types for the burger column controller: layer state encoding,
// screen coordinate type and play-field constants.
package burger_pkg;

    localparam int COORD_W = 10;
    localparam int FRAME_W = 640;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        REST    = 2'd0,
        PEND    = 2'd1,
        FALL    = 2'd2,
        STACKED = 2'd3
    } layer_state_t;

endpackage

// File: rtl/burger_column_ctrl_if.sv
// Interface bundling the chef step inputs and the column status outputs.
// The master side (game logic) drives steps; the slave side is the controller.
interface burger_column_ctrl_if
    import burger_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_SEGS   = 4
);

    logic                               step_valid;
    logic [$clog2(NUM_LAYERS)-1:0]      step_layer;
    logic [$clog2(NUM_SEGS)-1:0]        step_seg;
    logic [NUM_LAYERS*COORD_W-1:0]      layer_y;
    logic [NUM_LAYERS*2-1:0]            layer_state;
    logic [NUM_LAYERS*NUM_SEGS-1:0]     seg_mask;
    logic                               falling;
    logic [$clog2(NUM_LAYERS)-1:0]      active_layer;
    logic [$clog2(NUM_LAYERS+1)-1:0]    stack_count;
    logic                               column_done;

    modport master (
        output step_valid, step_layer, step_seg,
        input  layer_y, layer_state, seg_mask, falling,
               active_layer, stack_count, column_done
    );

    modport slave (
        input  step_valid, step_layer, step_seg,
        output layer_y, layer_state, seg_mask, falling,
               active_layer, stack_count, column_done
    );

endinterface

// File: rtl/burger_column_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after
// last_grant, wrapping around, and reports it one-hot.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid
);

    logic found;

    // Search above last_grant first, then wrap to the low indices
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i > int'(last_grant)) && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i <= int'(last_grant)) && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        grant_valid = found;
    end

endmodule

// File: rtl/burger_column_ctrl.sv
// Burger column controller: tracks stepped segments per ingredient layer,
// owns the single shared fall engine (round-robin grants, impact handoff)
// and counts layers landed on the plate.
// Optional build macro FALL_ACCEL_EN: fall speed starts at 1 on each grant
// or handoff and ramps every 4 moving frames up to 2*FALL_STEP.
module burger_column_ctrl
    import burger_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int NUM_SEGS    = 4,
    parameter int LAYER_Y0    = 100,
    parameter int LAYER_PITCH = 80,
    parameter int PLATE_Y     = 468,
    parameter int STACK_H     = 16,
    parameter int FALL_STEP   = 2
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    burger_column_ctrl_if.slave  bus
);

    localparam int LW = $clog2(NUM_LAYERS);
    localparam int CW = $clog2(NUM_LAYERS + 1);

    typedef logic [LW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    layer_state_t          state_q [NUM_LAYERS];
    layer_state_t          state_d [NUM_LAYERS];
    coord_t                y_q     [NUM_LAYERS];
    coord_t                y_d     [NUM_LAYERS];
    logic [NUM_SEGS-1:0]   mask_q  [NUM_LAYERS];
    logic [NUM_SEGS-1:0]   mask_d  [NUM_LAYERS];
    logic                  falling_q, falling_d;
    idx_t                  active_q, active_d;
    cnt_t                  stack_q, stack_d;
    idx_t                  last_grant_q, last_grant_d;
    logic                  done_q, done_d;

    logic [NUM_LAYERS-1:0] pend_req;
    logic [NUM_LAYERS-1:0] grant_oh;
    logic                  grant_valid;
    idx_t                  grant_idx;

    coord_t                cur_y;
    coord_t                plate_top;
    logic                  obs_found;
    coord_t                obs_y;
    idx_t                  obs_idx;
    logic                  layer_hit;
    coord_t                target;
    logic [3:0]            cur_step;
    logic                  move_ok;
    coord_t                next_y;

`ifdef FALL_ACCEL_EN
    logic [3:0]            speed_q, speed_d;
    logic [1:0]            move_cnt_q, move_cnt_d;

    assign cur_step = speed_q;
`else
    assign cur_step = 4'(FALL_STEP);
`endif

    // Collect layers waiting for the fall engine
    always_comb begin
        pend_req = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            pend_req[i] = (state_q[i] == PEND);
        end
    end

    rr_arbiter #(
        .NUM_REQ     (NUM_LAYERS)
    ) u_rr_arbiter (
        .req         (pend_req),
        .last_grant  (last_grant_q),
        .grant       (grant_oh),
        .grant_valid (grant_valid)
    );

    // Convert the one-hot grant into a layer index
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (grant_oh[i]) begin
                grant_idx = idx_t'(i);
            end
        end
    end

    // Fall datapath: plate top, nearest resting layer below, and the move test
    always_comb begin
        cur_y     = y_q[active_q];
        plate_top = coord_t'(PLATE_Y) - coord_t'(stack_q) * coord_t'(STACK_H);
        obs_found = 1'b0;
        obs_y     = '1;
        obs_idx   = '0;
        for (int j = 0; j < NUM_LAYERS; j++) begin
            if ((j != int'(active_q)) &&
                ((state_q[j] == REST) || (state_q[j] == PEND)) &&
                (y_q[j] > cur_y) &&
                (!obs_found || (y_q[j] < obs_y))) begin
                obs_found = 1'b1;
                obs_y     = y_q[j];
                obs_idx   = idx_t'(j);
            end
        end
        layer_hit = obs_found && (obs_y <= plate_top);
        target    = layer_hit ? obs_y : plate_top;
        move_ok   = (({1'b0, cur_y} + {7'b0, cur_step}) < {1'b0, target});
        next_y    = cur_y + coord_t'(cur_step);
    end

    // Next-state: stepping, round-robin grant, and per-frame fall/landing
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        mask_d       = mask_q;
        falling_d    = falling_q;
        active_d     = active_q;
        stack_d      = stack_q;
        last_grant_d = last_grant_q;
`ifdef FALL_ACCEL_EN
        speed_d      = speed_q;
        move_cnt_d   = move_cnt_q;
`endif

        if (bus.step_valid &&
            (int'(bus.step_layer) < NUM_LAYERS) &&
            (int'(bus.step_seg) < NUM_SEGS)) begin
            if (state_q[bus.step_layer] == REST) begin
                mask_d[bus.step_layer][bus.step_seg] = 1'b1;
                if (&mask_d[bus.step_layer]) begin
                    state_d[bus.step_layer] = PEND;
                end
            end
        end

        if (!falling_q) begin
            if (grant_valid) begin
                state_d[grant_idx] = FALL;
                falling_d          = 1'b1;
                active_d           = grant_idx;
`ifdef FALL_ACCEL_EN
                speed_d            = 4'd1;
                move_cnt_d         = 2'd0;
`endif
            end
        end else begin
            if (move_ok) begin
                y_d[active_q] = next_y;
`ifdef FALL_ACCEL_EN
                if (move_cnt_q == 2'd3) begin
                    move_cnt_d = 2'd0;
                    if (speed_q < 4'(FALL_STEP * 2)) begin
                        speed_d = speed_q + 4'd1;
                    end
                end else begin
                    move_cnt_d = move_cnt_q + 2'd1;
                end
`endif
            end else begin
                y_d[active_q] = target;
                if (layer_hit) begin
                    state_d[active_q] = REST;
                    mask_d[active_q]  = '0;
                    state_d[obs_idx]  = FALL;
                    mask_d[obs_idx]   = '0;
                    active_d          = obs_idx;
`ifdef FALL_ACCEL_EN
                    speed_d           = 4'd1;
                    move_cnt_d        = 2'd0;
`endif
                end else begin
                    state_d[active_q] = STACKED;
                    if (stack_q < cnt_t'(NUM_LAYERS)) begin
                        stack_d = stack_q + cnt_t'(1);
                    end
                    falling_d    = 1'b0;
                    last_grant_d = active_q;
                end
            end
        end

        done_d = (stack_d == cnt_t'(NUM_LAYERS));
    end

    // Column state registers with asynchronous active-low reset
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                state_q[i] <= REST;
                y_q[i]     <= coord_t'(LAYER_Y0 + i * LAYER_PITCH);
                mask_q[i]  <= '0;
            end
            falling_q    <= 1'b0;
            active_q     <= '0;
            stack_q      <= '0;
            last_grant_q <= idx_t'(NUM_LAYERS - 1);
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            mask_q       <= mask_d;
            falling_q    <= falling_d;
            active_q     <= active_d;
            stack_q      <= stack_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
        end
    end

`ifdef FALL_ACCEL_EN
    // Fall speed ramp registers
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            speed_q    <= 4'd1;
            move_cnt_q <= 2'd0;
        end else begin
            speed_q    <= speed_d;
            move_cnt_q <= move_cnt_d;
        end
    end
`endif

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pack
        assign bus.layer_y[COORD_W*g +: COORD_W]   = y_q[g];
        assign bus.layer_state[2*g +: 2]           = state_q[g];
        assign bus.seg_mask[NUM_SEGS*g +: NUM_SEGS] = mask_q[g];
    end

    assign bus.falling      = falling_q;
    assign bus.active_layer = active_q;
    assign bus.stack_count  = stack_q;
    assign bus.column_done  = done_q;

endmodule

// File: tb/tb_burger_column_ctrl.sv
// Directed self-checking bench for burger_column_ctrl (default build,
// constant fall step of 2 pixels per frame).
module tb_burger_column_ctrl;

    localparam logic [1:0] ST_REST    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_FALL    = 2'd2;
    localparam logic [1:0] ST_STACKED = 2'd3;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    burger_column_ctrl_if #(.NUM_LAYERS(4), .NUM_SEGS(4)) bus_if ();

    burger_column_ctrl #(
        .NUM_LAYERS  (4),
        .NUM_SEGS    (4),
        .LAYER_Y0    (100),
        .LAYER_PITCH (80),
        .PLATE_Y     (468),
        .STACK_H     (16),
        .FALL_STEP   (2)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus_if)
    );

    // Free-running frame clock
    always #5 frame_clk = ~frame_clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [9:0] get_y(input int i);
        return bus_if.layer_y[10*i +: 10];
    endfunction

    function automatic logic [1:0] get_state(input int i);
        return bus_if.layer_state[2*i +: 2];
    endfunction

    function automatic logic [3:0] get_mask(input int i);
        return bus_if.seg_mask[4*i +: 4];
    endfunction

    task automatic do_reset();
        bus_if.step_valid = 1'b0;
        bus_if.step_layer = '0;
        bus_if.step_seg   = '0;
        Reset_n           = 1'b0;
        repeat (2) @(negedge frame_clk);
        Reset_n           = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic step_frame(input int l, input int s);
        bus_if.step_valid = 1'b1;
        bus_if.step_layer = 2'(l);
        bus_if.step_seg   = 2'(s);
        @(posedge frame_clk);
        @(negedge frame_clk);
        bus_if.step_valid = 1'b0;
    endtask

    task automatic complete_layer(input int l);
        for (int s = 0; s < 4; s++) step_frame(l, s);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (get_y(i) !== 10'(100 + 80 * i)) begin
                n_fail++;
                $display("[TB] FAIL reset_y%0d: got %0d expected %0d", i, get_y(i), 100 + 80 * i);
            end
        end
        n_checks++;
        if (bus_if.layer_state !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_state: got %h expected 00", bus_if.layer_state); end
        n_checks++;
        if (bus_if.seg_mask !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_mask: got %h expected 0000", bus_if.seg_mask); end
        n_checks++;
        if ({bus_if.falling, bus_if.active_layer, bus_if.stack_count, bus_if.column_done} !== 7'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got falling=%0d active=%0d stack=%0d done=%0d expected all 0",
                     bus_if.falling, bus_if.active_layer, bus_if.stack_count, bus_if.column_done);
        end
    endtask

    task automatic test_stack_single();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            step_frame(3, s);
            n_checks++;
            if (get_mask(3) !== 4'((1 << (s + 1)) - 1) || get_state(3) !== ST_REST) begin
                n_fail++;
                $display("[TB] FAIL single_step%0d: got mask=%b state=%0d expected mask=%b state=0",
                         s, get_mask(3), get_state(3), 4'((1 << (s + 1)) - 1));
            end
        end
        step_frame(3, 3);
        n_checks++;
        if (get_state(3) !== ST_PEND || get_mask(3) !== 4'hF || bus_if.falling !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_pend: got state=%0d mask=%b falling=%0d expected 1/1111/0", get_state(3), get_mask(3), bus_if.falling);
        end
        idle(1);
        n_checks++;
        if (get_state(3) !== ST_FALL || bus_if.falling !== 1'b1 || bus_if.active_layer !== 2'd3 || get_y(3) !== 10'd340) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got state=%0d falling=%0d active=%0d y=%0d expected 2/1/3/340",
                     get_state(3), bus_if.falling, bus_if.active_layer, get_y(3));
        end
        idle(1);
        n_checks++;
        if (get_y(3) !== 10'd342) begin n_fail++; $display("[TB] FAIL single_first_move: got %0d expected 342", get_y(3)); end
        idle(62);
        n_checks++;
        if (get_y(3) !== 10'd466 || get_state(3) !== ST_FALL) begin
            n_fail++;
            $display("[TB] FAIL single_pre_land: got y=%0d state=%0d expected 466/2", get_y(3), get_state(3));
        end
        idle(1);
        n_checks++;
        if (get_y(3) !== 10'd468 || get_state(3) !== ST_STACKED || bus_if.stack_count !== 3'd1 ||
            bus_if.falling !== 1'b0 || bus_if.column_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_land: got y=%0d state=%0d stack=%0d falling=%0d done=%0d expected 468/3/1/0/0",
                     get_y(3), get_state(3), bus_if.stack_count, bus_if.falling, bus_if.column_done);
        end
    endtask

    task automatic test_no_cascade();
        complete_layer(2);
        n_checks++;
        if (get_state(2) !== ST_PEND) begin n_fail++; $display("[TB] FAIL nocasc_pend: got %0d expected 1", get_state(2)); end
        idle(1);
        n_checks++;
        if (get_state(2) !== ST_FALL || get_y(2) !== 10'd260) begin
            n_fail++;
            $display("[TB] FAIL nocasc_grant: got state=%0d y=%0d expected 2/260", get_state(2), get_y(2));
        end
        idle(40);
        n_checks++;
        if (get_y(2) !== 10'd340 || get_state(2) !== ST_FALL) begin
            n_fail++;
            $display("[TB] FAIL nocasc_pass340: got y=%0d state=%0d expected 340/2", get_y(2), get_state(2));
        end
        idle(55);
        n_checks++;
        if (get_y(2) !== 10'd450) begin n_fail++; $display("[TB] FAIL nocasc_pre_land: got %0d expected 450", get_y(2)); end
        idle(1);
        n_checks++;
        if (get_y(2) !== 10'd452 || get_state(2) !== ST_STACKED || bus_if.stack_count !== 3'd2 || bus_if.falling !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nocasc_land: got y=%0d state=%0d stack=%0d falling=%0d expected 452/3/2/0",
                     get_y(2), get_state(2), bus_if.stack_count, bus_if.falling);
        end
    endtask

    task automatic test_cascade_handoff();
        do_reset();
        complete_layer(2);
        idle(1);
        n_checks++;
        if (get_state(2) !== ST_FALL || bus_if.active_layer !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL casc_grant: got state=%0d active=%0d expected 2/2", get_state(2), bus_if.active_layer);
        end
        idle(39);
        n_checks++;
        if (get_y(2) !== 10'd338 || get_state(3) !== ST_REST) begin
            n_fail++;
            $display("[TB] FAIL casc_pre_hit: got y2=%0d state3=%0d expected 338/0", get_y(2), get_state(3));
        end
        idle(1);
        n_checks++;
        if (get_y(2) !== 10'd340 || get_state(2) !== ST_REST || get_mask(2) !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL casc_struck_by: got y2=%0d state2=%0d mask2=%b expected 340/0/0000", get_y(2), get_state(2), get_mask(2));
        end
        n_checks++;
        if (get_state(3) !== ST_FALL || bus_if.active_layer !== 2'd3 || bus_if.falling !== 1'b1 ||
            bus_if.stack_count !== 3'd0 || get_y(3) !== 10'd340) begin
            n_fail++;
            $display("[TB] FAIL casc_handoff: got state3=%0d active=%0d falling=%0d stack=%0d y3=%0d expected 2/3/1/0/340",
                     get_state(3), bus_if.active_layer, bus_if.falling, bus_if.stack_count, get_y(3));
        end
    endtask

    task automatic test_arbitration();
        step_frame(1, 0);
        step_frame(1, 0);
        n_checks++;
        if (get_mask(1) !== 4'b0001 || get_state(1) !== ST_REST) begin
            n_fail++;
            $display("[TB] FAIL ign_restep: got mask=%b state=%0d expected 0001/0", get_mask(1), get_state(1));
        end
        step_frame(3, 1);
        n_checks++;
        if (get_mask(3) !== 4'h0 || get_state(3) !== ST_FALL) begin
            n_fail++;
            $display("[TB] FAIL ign_fall_layer: got mask=%b state=%0d expected 0000/2", get_mask(3), get_state(3));
        end
        for (int s = 1; s < 4; s++) step_frame(1, s);
        complete_layer(0);
        n_checks++;
        if (get_state(0) !== ST_PEND || get_state(1) !== ST_PEND || get_y(3) !== 10'd360) begin
            n_fail++;
            $display("[TB] FAIL arb_both_pend: got s0=%0d s1=%0d y3=%0d expected 1/1/360", get_state(0), get_state(1), get_y(3));
        end
        idle(53);
        n_checks++;
        if (get_y(3) !== 10'd466 || get_state(3) !== ST_FALL) begin
            n_fail++;
            $display("[TB] FAIL arb_pre_land: got y3=%0d state3=%0d expected 466/2", get_y(3), get_state(3));
        end
        idle(1);
        n_checks++;
        if (get_state(3) !== ST_STACKED || bus_if.stack_count !== 3'd1 || bus_if.falling !== 1'b0 || get_y(3) !== 10'd468) begin
            n_fail++;
            $display("[TB] FAIL arb_land3: got state3=%0d stack=%0d falling=%0d y3=%0d expected 3/1/0/468",
                     get_state(3), bus_if.stack_count, bus_if.falling, get_y(3));
        end
        idle(1);
        n_checks++;
        if (get_state(0) !== ST_FALL || bus_if.active_layer !== 2'd0 || bus_if.falling !== 1'b1 ||
            get_state(1) !== ST_PEND || get_y(0) !== 10'd100) begin
            n_fail++;
            $display("[TB] FAIL arb_wrap_grant: got s0=%0d active=%0d falling=%0d s1=%0d y0=%0d expected 2/0/1/1/100",
                     get_state(0), bus_if.active_layer, bus_if.falling, get_state(1), get_y(0));
        end
        step_frame(3, 2);
        n_checks++;
        if (get_mask(3) !== 4'h0 || get_state(3) !== ST_STACKED || get_y(0) !== 10'd102) begin
            n_fail++;
            $display("[TB] FAIL ign_stacked: got mask3=%b state3=%0d y0=%0d expected 0000/3/102", get_mask(3), get_state(3), get_y(0));
        end
    endtask

    task automatic test_reset_mid_fall();
        do_reset();
        complete_layer(2);
        idle(1);
        idle(20);
        n_checks++;
        if (get_y(2) !== 10'd300 || get_state(2) !== ST_FALL) begin
            n_fail++;
            $display("[TB] FAIL midrst_pre: got y2=%0d state2=%0d expected 300/2", get_y(2), get_state(2));
        end
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.layer_y !== {10'd340, 10'd260, 10'd180, 10'd100}) begin
            n_fail++;
            $display("[TB] FAIL midrst_y: got %h expected %h", bus_if.layer_y, {10'd340, 10'd260, 10'd180, 10'd100});
        end
        n_checks++;
        if (bus_if.layer_state !== 8'h00 || bus_if.seg_mask !== 16'h0 || bus_if.falling !== 1'b0 || bus_if.stack_count !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL midrst_ctrl: got state=%h mask=%h falling=%0d stack=%0d expected 00/0000/0/0",
                     bus_if.layer_state, bus_if.seg_mask, bus_if.falling, bus_if.stack_count);
        end
        @(negedge frame_clk);
        Reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_column_done();
        do_reset();
        for (int l = 3; l >= 0; l--) begin
            int cnt = 0;
            complete_layer(l);
            while (get_state(l) !== ST_STACKED && cnt < 300) begin
                idle(1);
                cnt++;
            end
            n_checks++;
            if (get_state(l) !== ST_STACKED) begin
                n_fail++;
                $display("[TB] FAIL done_land%0d: got state=%0d expected 3 within 300 frames", l, get_state(l));
            end
            n_checks++;
            if (get_y(l) !== 10'(468 - 16 * (3 - l)) || bus_if.stack_count !== 3'(4 - l) ||
                bus_if.column_done !== (l == 0)) begin
                n_fail++;
                $display("[TB] FAIL done_stack%0d: got y=%0d stack=%0d done=%0d expected %0d/%0d/%0d",
                         l, get_y(l), bus_if.stack_count, bus_if.column_done, 468 - 16 * (3 - l), 4 - l, (l == 0));
            end
        end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] start");
        test_reset();
        test_stack_single();
        test_no_cascade();
        test_cascade_handoff();
        test_arbitration();
        test_reset_mid_fall();
        test_column_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
